rst_ctrl: RTL and testbench
===========================

RST_CTRL -- requirements
Module: rst_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 3: number of staged reset outputs (1..8).
REQ-002 SHALL have parameter RELEASE_GAP, default 16: cycles between consecutive domain releases (>=1).
REQ-003 SHALL have parameter HOLD_CYCLES, default 8: cycles all domains stay asserted after a requested reset (>=1).
REQ-004 SHALL have parameter WDT_LIMIT, default 2^20: watchdog expiry count (>=2, fits 24 bits).
REQ-005 SHALL have one clock and an asynchronous, active-high reset; no other clock or reset input exists.
REQ-006 SHALL have port clk  input  1  system clock from the system controller.
REQ-007 SHALL have port rst  input  1  asynchronous active-high system reset from the system controller.
REQ-008 SHALL have port sw_rst_req  input  1  software reset request, sampled per cycle.
REQ-009 SHALL have port wdt_en  input  1  watchdog enable, level.
REQ-010 SHALL have port wdt_kick  input  1  watchdog restart, sampled per cycle.
REQ-011 SHALL have port rst_out  output  NUM_DOMAINS  per-domain active-high reset; bit 0 is released first.
REQ-012 SHALL have port ready  output  1  high only when every domain is released.
REQ-013 SHALL have port cause  output  2  last reset cause: 00 system, 01 software, 10 watchdog, 11 unused.

Function
REQ-014 SHALL implement FSM states ASSERT, RELEASE, RUN, HOLD.
REQ-015 SHALL pass rst deassertion through a 2-flop synchronizer; ASSERT exits to RELEASE in the cycle the synchronized reset first reads low (cycle T).
REQ-016 SHALL, in RELEASE, clear rst_out[i] at cycle T + (i+1)*RELEASE_GAP using one gap counter, with no other rst_out change.
REQ-017 SHALL set ready and enter RUN in the same cycle that rst_out[NUM_DOMAINS-1] clears.
REQ-018 SHALL, in RUN with sw_rst_req=1, set rst_out to all ones, clear ready, set cause=01 and enter HOLD on the next edge.
REQ-019 SHALL, in RUN with wdt_en=1, increment the 24-bit watchdog counter each cycle; wdt_kick=1 clears it to 0.
REQ-020 SHALL, when the counter reaches WDT_LIMIT-1 with no kick in that cycle, act as REQ-018 but with cause=10.
REQ-021 SHALL give kick priority over expiry in the same cycle, and software priority over watchdog in the same cycle (cause=01).
REQ-022 SHALL hold the watchdog counter at 0 while wdt_en=0 or state is not RUN.
REQ-023 SHALL stay in HOLD exactly HOLD_CYCLES cycles, then enter RELEASE with the gap counter restarted (same T-relative timing as REQ-016).
REQ-024 SHALL ignore sw_rst_req and watchdog outside RUN; a request held high across RUN entry is acted on in the first RUN cycle.
REQ-025 SHALL keep cause stable until the next reset event.
REQ-026 SHALL keep rst_out glitch-free: each bit is driven directly from a flop.

Reset
REQ-027 SHALL, on rst=1 at any time, including mid-RELEASE or mid-HOLD, immediately and asynchronously drive rst_out all ones, ready=0, cause=00, state ASSERT, and clear all counters.
REQ-028 SHALL keep all outputs at reset values while rst=1 and until REQ-015 completes.

Structure
REQ-029 SHALL place state encoding, cause encoding (CAUSE_SYS, CAUSE_SW, CAUSE_WDT) and the synchronizer depth constant in shared package rst_ctrl_pkg.
REQ-030 SHALL implement the synchronizer as sub-module rst_sync (async assert, synchronous deassert, 2 stages).

Verification (NUM_DOMAINS=3, RELEASE_GAP=4, HOLD_CYCLES=8, WDT_LIMIT=100)
REQ-031 SHALL cover: rst released -> synchronized low at T; rst_out 111->110 at T+4, 100 at T+8, 000 plus ready=1 at T+12; cause=00.
REQ-032 SHALL cover: 1-cycle sw_rst_req in RUN -> rst_out=111 and ready=0 next edge, cause=01, 8 HOLD cycles, then the 4-cycle staged release.
REQ-033 SHALL cover: wdt_en=1 with no kicks -> expiry 100 cycles after RUN entry, cause=10; kicking every 50 cycles -> no reset over 1000 cycles.
REQ-034 SHALL cover: sw_rst_req on the expiry cycle -> cause=01; wdt_kick on the expiry cycle -> no reset.
REQ-035 SHALL cover: rst pulsed mid-RELEASE (after rst_out=110) -> rst_out=111 asynchronously, cause=00, full sequence restarts.

Source files
------------

// File: rtl/rst_ctrl_pkg.sv
// Shared constants for the reset controller: FSM state codes, reset-cause codes
// and the reset synchronizer depth.
package rst_ctrl_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned WDT_W       = 24;

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_SYS = 2'b00;
  localparam cause_t CAUSE_SW  = 2'b01;
  localparam cause_t CAUSE_WDT = 2'b10;

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after STAGES clean clock edges.
module rst_sync
  import rst_ctrl_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  output logic o_rst_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= r_sync << 1;
    end
  end

  assign o_rst_sync = r_sync[STAGES-1];

endmodule

// File: rtl/rst_ctrl.sv
// Staged reset controller: releases NUM_DOMAINS resets one gap apart after a system
// reset, software request or watchdog expiry, and records the last reset cause.
module rst_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned RELEASE_GAP = 16,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned WDT_LIMIT   = 1 << 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  input  logic                   wdt_en,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic [1:0]             cause
);

  localparam logic [31:0]      GAP_LAST  = 32'(RELEASE_GAP - 1);
  localparam logic [31:0]      HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [WDT_W-1:0] WDT_LAST  = WDT_W'(WDT_LIMIT - 1);

  logic                   w_rst_sync;
  logic [1:0]             r_state, w_state_next;
  logic [NUM_DOMAINS-1:0] r_rst_out, w_rst_out_next, w_rst_out_shift;
  logic                   r_ready, w_ready_next;
  cause_t                 r_cause, w_cause_next;
  logic [31:0]            r_gap_cnt, w_gap_cnt_next;
  logic [31:0]            r_hold_cnt, w_hold_cnt_next;
  logic [WDT_W-1:0]       r_wdt_cnt, w_wdt_cnt_next;
  logic                   w_release_tick;
  logic                   w_gap_done;
  logic                   w_last_domain;
  logic                   w_wdt_expire;

  rst_sync #(
    .STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk       (clk),
    .rst       (rst),
    .o_rst_sync(w_rst_sync)
  );

  // The cycle that leaves ASSERT or HOLD already counts as the first gap cycle,
  // so both release paths share identical T-relative timing.
  assign w_release_tick = ((r_state == ST_ASSERT) && !w_rst_sync) ||
                          (r_state == ST_RELEASE) ||
                          ((r_state == ST_HOLD) && (r_hold_cnt == HOLD_LAST));
  assign w_gap_done      = (r_gap_cnt == GAP_LAST);
  assign w_rst_out_shift = r_rst_out << 1;
  assign w_last_domain   = (w_rst_out_shift == '0);
  assign w_wdt_expire    = (r_state == ST_RUN) && wdt_en && !wdt_kick &&
                           (r_wdt_cnt == WDT_LAST);

  always_comb begin
    w_state_next    = r_state;
    w_rst_out_next  = r_rst_out;
    w_ready_next    = r_ready;
    w_cause_next    = r_cause;
    w_gap_cnt_next  = r_gap_cnt;
    w_hold_cnt_next = r_hold_cnt;
    w_wdt_cnt_next  = '0;

    if (w_release_tick) begin
      w_state_next    = ST_RELEASE;
      w_hold_cnt_next = '0;
      if (w_gap_done) begin
        w_gap_cnt_next = '0;
        w_rst_out_next = w_rst_out_shift;
        if (w_last_domain) begin
          w_state_next = ST_RUN;
          w_ready_next = 1'b1;
        end
      end else begin
        w_gap_cnt_next = r_gap_cnt + 1'b1;
      end
    end else if (r_state == ST_HOLD) begin
      w_hold_cnt_next = r_hold_cnt + 1'b1;
    end else if (r_state == ST_RUN) begin
      if (sw_rst_req || w_wdt_expire) begin
        w_state_next    = ST_HOLD;
        w_rst_out_next  = '1;
        w_ready_next    = 1'b0;
        w_cause_next    = sw_rst_req ? CAUSE_SW : CAUSE_WDT;
        w_hold_cnt_next = '0;
      end else if (wdt_en && !wdt_kick) begin
        w_wdt_cnt_next = r_wdt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_ASSERT;
      r_rst_out  <= '1;
      r_ready    <= 1'b0;
      r_cause    <= CAUSE_SYS;
      r_gap_cnt  <= '0;
      r_hold_cnt <= '0;
      r_wdt_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rst_out  <= w_rst_out_next;
      r_ready    <= w_ready_next;
      r_cause    <= w_cause_next;
      r_gap_cnt  <= w_gap_cnt_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_wdt_cnt  <= w_wdt_cnt_next;
    end
  end

  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_rst_out
    assign rst_out[gi] = r_rst_out[gi];
  end

  assign ready = r_ready;
  assign cause = r_cause;

endmodule

// File: tb/tb_rst_ctrl.sv
// Bench for rst_ctrl: phase/elapsed-time reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rst_ctrl;

  localparam int N     = 3;
  localparam int GAP   = 4;
  localparam int HOLD  = 8;
  localparam int LIMIT = 100;

  localparam int M_RST  = 0;
  localparam int M_REL  = 1;
  localparam int M_RUN  = 2;
  localparam int M_HOLD = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         sw_rst_req;
  logic         wdt_en;
  logic         wdt_kick;
  logic [N-1:0] rst_out;
  logic         ready;
  logic [1:0]   cause;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b1;

  // Model: current phase plus elapsed cycles inside it.
  int         m_phase = M_RST;
  int         m_low   = 0;
  int         m_t     = 0;
  int         m_h     = 0;
  int         m_wdt   = 0;
  logic [1:0] m_cause = 2'b00;

  rst_ctrl #(
    .NUM_DOMAINS(N),
    .RELEASE_GAP(GAP),
    .HOLD_CYCLES(HOLD),
    .WDT_LIMIT  (LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_rst_req(sw_rst_req),
    .wdt_en    (wdt_en),
    .wdt_kick  (wdt_kick),
    .rst_out   (rst_out),
    .ready     (ready),
    .cause     (cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_RST;
    m_low   = 0;
    m_t     = 0;
    m_h     = 0;
    m_wdt   = 0;
    m_cause = 2'b00;
  endtask

  task automatic model_enter_hold(input logic [1:0] c);
    m_cause = c;
    m_wdt   = 0;
    if (HOLD == 1) begin
      m_phase = M_REL;
      m_t     = 0;
    end else begin
      m_phase = M_HOLD;
      m_h     = 1;
    end
  endtask

  function automatic logic [N-1:0] exp_rst_out();
    logic [N-1:0] ones;
    ones = '1;
    if (m_phase == M_RUN) return '0;
    if (m_phase == M_REL) return ones << (m_t / GAP);
    return ones;
  endfunction

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        M_RST: begin
          m_low++;
          if (m_low == 2) begin
            m_phase = M_REL;
            m_t     = 0;
          end
        end
        M_REL: begin
          m_t++;
          if (m_t == N * GAP) begin
            m_phase = M_RUN;
            m_wdt   = 0;
          end
        end
        M_RUN: begin
          if (sw_rst_req)
            model_enter_hold(2'b01);
          else if (wdt_en && !wdt_kick && m_wdt == LIMIT - 1)
            model_enter_hold(2'b10);
          else if (!wdt_en || wdt_kick)
            m_wdt = 0;
          else
            m_wdt++;
        end
        default: begin
          m_h++;
          if (m_h == HOLD) begin
            m_phase = M_REL;
            m_t     = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model rst_out", 32'(rst_out), 32'(exp_rst_out()));
      check("model ready", 32'(ready), 32'(m_phase == M_RUN));
      check("model cause", 32'(cause), 32'(m_cause));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rst_left;
    rst = 1'b1; sw_rst_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;
    cyc(3);
    check("reset rst_out", 32'(rst_out), 32'h7);
    check("reset ready", 32'(ready), 32'h0);
    check("reset cause", 32'(cause), 32'h0);

    // Power-up staged release
    rst = 1'b0;
    cyc(2);
    check("T rst_out", 32'(rst_out), 32'h7);
    cyc(3);
    check("T+3 rst_out", 32'(rst_out), 32'h7);
    cyc(1);
    check("T+4 rst_out", 32'(rst_out), 32'h6);
    cyc(4);
    check("T+8 rst_out", 32'(rst_out), 32'h4);
    cyc(3);
    check("T+11 ready", 32'(ready), 32'h0);
    cyc(1);
    check("T+12 rst_out", 32'(rst_out), 32'h0);
    check("T+12 ready", 32'(ready), 32'h1);
    check("T+12 cause", 32'(cause), 32'h0);

    // Software reset: hold then staged release
    sw_rst_req = 1'b1;
    cyc(1);
    sw_rst_req = 1'b0;
    check("sw rst_out", 32'(rst_out), 32'h7);
    check("sw ready", 32'(ready), 32'h0);
    check("sw cause", 32'(cause), 32'h1);
    cyc(10);
    check("sw hold+10 rst_out", 32'(rst_out), 32'h7);
    cyc(1);
    check("sw first release", 32'(rst_out), 32'h6);
    cyc(4);
    check("sw second release", 32'(rst_out), 32'h4);
    cyc(4);
    check("sw done rst_out", 32'(rst_out), 32'h0);
    check("sw done ready", 32'(ready), 32'h1);
    check("sw done cause", 32'(cause), 32'h1);

    // Watchdog expiry without kicks
    wdt_en = 1'b1;
    cyc(99);
    check("wdt pre-expiry ready", 32'(ready), 32'h1);
    cyc(1);
    check("wdt expiry rst_out", 32'(rst_out), 32'h7);
    check("wdt expiry cause", 32'(cause), 32'h2);
    cyc(19);
    check("wdt recover ready", 32'(ready), 32'h1);
    check("wdt recover cause", 32'(cause), 32'h2);

    // Kicking every 50 cycles keeps the system running
    repeat (20) begin
      cyc(49);
      wdt_kick = 1'b1;
      cyc(1);
      wdt_kick = 1'b0;
    end
    check("kicked ready", 32'(ready), 32'h1);
    check("kicked rst_out", 32'(rst_out), 32'h0);

    // Software request on the expiry cycle wins
    wdt_en = 1'b0;
    cyc(1);
    wdt_en = 1'b1;
    cyc(99);
    check("expiry-cycle ready", 32'(ready), 32'h1);
    sw_rst_req = 1'b1;
    cyc(1);
    sw_rst_req = 1'b0;
    check("sw on expiry cause", 32'(cause), 32'h1);
    check("sw on expiry rst_out", 32'(rst_out), 32'h7);
    cyc(19);
    check("sw on expiry recover", 32'(ready), 32'h1);

    // Kick on the expiry cycle prevents the reset
    cyc(99);
    wdt_kick = 1'b1;
    cyc(1);
    wdt_kick = 1'b0;
    check("kick on expiry ready", 32'(ready), 32'h1);
    cyc(5);
    check("kick on expiry later", 32'(rst_out), 32'h0);

    // System reset in the middle of a release
    sw_rst_req = 1'b1;
    cyc(1);
    sw_rst_req = 1'b0;
    cyc(11);
    check("mid-release rst_out", 32'(rst_out), 32'h6);
    #1 rst = 1'b1;
    #1;
    check("async rst_out", 32'(rst_out), 32'h7);
    check("async ready", 32'(ready), 32'h0);
    check("async cause", 32'(cause), 32'h0);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    check("restart T rst_out", 32'(rst_out), 32'h7);
    cyc(4);
    check("restart T+4 rst_out", 32'(rst_out), 32'h6);
    cyc(8);
    check("restart T+12 rst_out", 32'(rst_out), 32'h0);
    check("restart ready", 32'(ready), 32'h1);
    check("restart cause", 32'(cause), 32'h0);

    // Randomized traffic against the model
    rst_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rst) begin
        if (rst_left == 0) rst = 1'b0;
        else rst_left--;
      end else if ($urandom_range(0, 499) == 0) begin
        rst      = 1'b1;
        rst_left = int'($urandom_range(0, 2));
      end
      sw_rst_req = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) wdt_en = ~wdt_en;
      wdt_kick = ($urandom_range(0, 149) == 0);
      cyc(1);
    end

    rst = 1'b0; sw_rst_req = 1'b0; wdt_kick = 1'b0; wdt_en = 1'b0;
    cyc(40);
    check("final ready", 32'(ready), 32'h1);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
